// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control block: control-word bit layout,
// widths, forwarding-select encodings and the per-stage register records.
package ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int CTRL_W = 11;

  // Decoder word layout, bit 10 down to bit 0
  localparam int B_REGDST   = 10;
  localparam int B_BRANCH   = 9;
  localparam int B_BNE      = 8;
  localparam int B_MEMREAD  = 7;
  localparam int B_MEMTOREG = 6;
  localparam int B_MEMWRITE = 5;
  localparam int B_ALUSRC   = 4;
  localparam int B_REGWRITE = 3;
  localparam int B_JUMP     = 2;
  localparam int B_ALUOP_HI = 1;
  localparam int B_ALUOP_LO = 0;

  typedef logic [CTRL_W-1:0] ctrl_word_t;
  typedef logic [REG_W-1:0]  reg_num_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam ctrl_word_t BUBBLE = '0;

  // ID/EX keeps every field EX, MEM or WB still needs; jump has no effect past ID
  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       bne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    reg_num_t   rs;
    reg_num_t   rt;
    reg_num_t   rd;
  } idex_t;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    logic     mem_to_reg;
    logic     reg_write;
    reg_num_t wreg;
  } exmem_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    reg_num_t wreg;
  } memwb_t;

  // A later stage supplies src only if it writes a real register matching src
  function automatic logic reg_hit(input logic reg_write, input reg_num_t wreg,
                                   input reg_num_t src);
    return reg_write && (wreg != '0) && (wreg == src);
  endfunction

  function automatic idex_t unpack_id(input ctrl_word_t c, input reg_num_t rs,
                                      input reg_num_t rt, input reg_num_t rd);
    idex_t r;
    r.regdst     = c[B_REGDST];
    r.branch     = c[B_BRANCH];
    r.bne        = c[B_BNE];
    r.mem_read   = c[B_MEMREAD];
    r.mem_to_reg = c[B_MEMTOREG];
    r.mem_write  = c[B_MEMWRITE];
    r.alu_src    = c[B_ALUSRC];
    r.reg_write  = c[B_REGWRITE];
    r.alu_op     = c[B_ALUOP_HI:B_ALUOP_LO];
    r.rs         = rs;
    r.rt         = rt;
    r.rd         = rd;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-to-datapath control bundle for ctrl_pipe. The counter outputs exist
// only when CTRL_PIPE_STATS_EN is defined.
interface ctrl_pipe_if;
  import ctrl_pkg::*;

  ctrl_word_t id_ctrl;
  reg_num_t   id_rs;
  reg_num_t   id_rt;
  reg_num_t   id_rd;
  logic       ex_zero;

  logic       ex_RegDst;
  logic       ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic       branch_taken;
  logic       jump_id;
  logic       mem_MemRead;
  logic       mem_MemWrite;
  logic       wb_RegWrite;
  logic       wb_MemtoReg;
  reg_num_t   wb_wreg;
  logic       pc_write;
  logic       ifid_write;
  logic       if_flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, branch_taken, jump_id,
    input  mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, wb_wreg,
    input  pc_write, ifid_write, if_flush, forward_a, forward_b
`ifdef CTRL_PIPE_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, branch_taken, jump_id,
    output mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, wb_wreg,
    output pc_write, ifid_write, if_flush, forward_a, forward_b
`ifdef CTRL_PIPE_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage forwarding select for one ALU operand; the nearer producer
// (EX/MEM) takes priority over MEM/WB.
module fwd_unit
  import ctrl_pkg::*;
(
  input  reg_num_t   src,
  input  logic       exmem_reg_write,
  input  reg_num_t   exmem_wreg,
  input  logic       memwb_reg_write,
  input  reg_num_t   memwb_wreg,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(exmem_reg_write, exmem_wreg, src)) begin
      sel = FWD_EXMEM;
    end else if (reg_hit(memwb_reg_write, memwb_wreg, src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoder's control word through ID/EX, EX/MEM and MEM/WB, with
// load-use stalls, branch/jump flushes and forwarding. Optional event counters
// are built when CTRL_PIPE_STATS_EN is defined.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input logic        clk,
  input logic        reset,
  ctrl_pipe_if.slave bus
);

  idex_t  idex_reg,  idex_next;
  exmem_t exmem_reg, exmem_next;
  memwb_t memwb_reg, memwb_next;

  logic stall;
  logic branch_taken;
  logic jump_id;
  logic if_flush;

  reg_num_t   fwd_src [2];
  logic [1:0] fwd_sel [2];

  // Hazard detection works on the instruction now in EX against the one in ID
  always_comb begin
    stall = idex_reg.mem_read && (idex_reg.rt != '0) &&
            ((idex_reg.rt == bus.id_rs) || (idex_reg.rt == bus.id_rt));
    branch_taken = (idex_reg.branch & bus.ex_zero) | (idex_reg.bne & ~bus.ex_zero);
    jump_id  = bus.id_ctrl[B_JUMP] & ~stall & ~branch_taken;
    if_flush = branch_taken | jump_id;
  end

  // A taken branch squashes the wrong-path ID word; a stall holds it in ID
  always_comb begin
    idex_next = unpack_id(BUBBLE, '0, '0, '0);
    if (!(stall || branch_taken)) begin
      idex_next = unpack_id(bus.id_ctrl, bus.id_rs, bus.id_rt, bus.id_rd);
    end
  end

  always_comb begin
    exmem_next            = '0;
    exmem_next.mem_read   = idex_reg.mem_read;
    exmem_next.mem_write  = idex_reg.mem_write;
    exmem_next.mem_to_reg = idex_reg.mem_to_reg;
    exmem_next.reg_write  = idex_reg.reg_write;
    exmem_next.wreg       = idex_reg.regdst ? idex_reg.rd : idex_reg.rt;
  end

  always_comb begin
    memwb_next            = '0;
    memwb_next.reg_write  = exmem_reg.reg_write;
    memwb_next.mem_to_reg = exmem_reg.mem_to_reg;
    memwb_next.wreg       = exmem_reg.wreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_reg  <= '0;
      exmem_reg <= '0;
      memwb_reg <= '0;
    end else begin
      idex_reg  <= idex_next;
      exmem_reg <= exmem_next;
      memwb_reg <= memwb_next;
    end
  end

  assign fwd_src[0] = idex_reg.rs;
  assign fwd_src[1] = idex_reg.rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_unit u_fwd (
      .src             (fwd_src[gi]),
      .exmem_reg_write (exmem_reg.reg_write),
      .exmem_wreg      (exmem_reg.wreg),
      .memwb_reg_write (memwb_reg.reg_write),
      .memwb_wreg      (memwb_reg.wreg),
      .sel             (fwd_sel[gi])
    );
  end

  assign bus.ex_RegDst    = idex_reg.regdst;
  assign bus.ex_ALUSrc    = idex_reg.alu_src;
  assign bus.ex_ALUOp     = idex_reg.alu_op;
  assign bus.branch_taken = branch_taken;
  assign bus.jump_id      = jump_id;
  assign bus.mem_MemRead  = exmem_reg.mem_read;
  assign bus.mem_MemWrite = exmem_reg.mem_write;
  assign bus.wb_RegWrite  = memwb_reg.reg_write;
  assign bus.wb_MemtoReg  = memwb_reg.mem_to_reg;
  assign bus.wb_wreg      = memwb_reg.wreg;
  // A taken branch redirects the PC even when a load-use stall is pending
  assign bus.pc_write     = ~stall | branch_taken;
  assign bus.ifid_write   = ~stall | branch_taken;
  assign bus.if_flush     = if_flush;
  assign bus.forward_a    = fwd_sel[0];
  assign bus.forward_b    = fwd_sel[1];

`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Stalls overridden by a taken branch are not real stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && !branch_taken) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (if_flush) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;
`endif

endmodule
